// File: rtl/sync_fifo_pkg.sv
// Shared pointer arithmetic for the systolic-array synchronous FIFO pointer blocks.
// Pointers are {wrap, idx} with idx in 0..depth-1; idx is zero-extended into ptr_t.
package sync_fifo_pkg;

    localparam int unsigned PtrIdxMaxW = 16;

    typedef struct packed {
        logic                  wrap;
        logic [PtrIdxMaxW-1:0] idx;
    } ptr_t;

    function automatic int unsigned calc_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned max_push);
        return $clog2(max_push + 1);
    endfunction

    function automatic int unsigned calc_free_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned fifo_occ(input ptr_t w, input ptr_t r,
                                             input int unsigned depth);
        if (w.wrap == r.wrap) begin
            return 32'(w.idx) - 32'(r.idx);
        end
        return depth - 32'(r.idx) + 32'(w.idx);
    endfunction

    // Requires ptr.idx < depth and n <= depth, so a single subtraction suffices.
    function automatic ptr_t fifo_ptr_add(input ptr_t ptr, input int unsigned n,
                                          input int unsigned depth);
        ptr_t        res;
        int unsigned sum;
        sum = 32'(ptr.idx) + n;
        if (sum >= depth) begin
            res.idx  = PtrIdxMaxW'(sum - depth);
            res.wrap = ~ptr.wrap;
        end else begin
            res.idx  = PtrIdxMaxW'(sum);
            res.wrap = ptr.wrap;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr_add.sv
// Modulo-DEPTH pointer increment with wrap-bit toggle; purely combinational.
module sync_fifo_ptr_add
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned IDX_W = calc_idx_w(DEPTH),
    parameter int unsigned CNT_W = 2
) (
    input  logic [IDX_W:0]   ptr_i,
    input  logic [CNT_W-1:0] n_i,
    output logic [IDX_W:0]   ptr_o
);

    ptr_t ptr_in;
    ptr_t ptr_sum;
    logic unused_idx_hi;

    always_comb begin
        ptr_in      = '0;
        ptr_in.wrap = ptr_i[IDX_W];
        ptr_in.idx  = PtrIdxMaxW'(ptr_i[IDX_W-1:0]);
        ptr_sum     = fifo_ptr_add(ptr_in, 32'(n_i), DEPTH);
        ptr_o       = {ptr_sum.wrap, ptr_sum.idx[IDX_W-1:0]};
    end

    assign unused_idx_hi = ^ptr_sum.idx[PtrIdxMaxW-1:IDX_W];

endmodule

// File: rtl/sync_fifo_wptr_multi.sv
// Multi-push write-pointer controller: any DEPTH >= 2, partial acceptance,
// free count / almost-full, flush to the read pointer, and sticky overflow.
module sync_fifo_wptr_multi
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 6,
    parameter int unsigned MAX_PUSH  = 2,
    parameter int unsigned AF_THRESH = 1,
    parameter int unsigned IDX_W     = calc_idx_w(DEPTH),
    parameter int unsigned CNT_W     = calc_cnt_w(MAX_PUSH),
    parameter int unsigned FREE_W    = calc_free_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [CNT_W-1:0]  push_cnt,
    input  logic [IDX_W:0]    r_ptr,
    input  logic              clear_ovf,
    output logic [IDX_W:0]    w_ptr,
    output logic [CNT_W-1:0]  push_ack,
    output logic [FREE_W-1:0] free_cnt,
    output logic              full,
    output logic              almost_full,
    output logic              overflow
);

    localparam int unsigned AW = FREE_W + 1;

    logic [IDX_W:0] w_ptr_q, w_ptr_d, w_ptr_inc;
    logic           overflow_q, overflow_d;
    ptr_t           w_p, r_p;
    logic [AW-1:0]  occ, free_ext, req, ack_ext;

    always_comb begin
        w_p      = '0;
        w_p.wrap = w_ptr_q[IDX_W];
        w_p.idx  = PtrIdxMaxW'(w_ptr_q[IDX_W-1:0]);
        r_p      = '0;
        r_p.wrap = r_ptr[IDX_W];
        r_p.idx  = PtrIdxMaxW'(r_ptr[IDX_W-1:0]);

        occ      = AW'(fifo_occ(w_p, r_p, DEPTH));
        free_ext = AW'(DEPTH) - occ;

        // Offers beyond MAX_PUSH are illegal; clamp rather than over-advance.
        req = (AW'(push_cnt) > AW'(MAX_PUSH)) ? AW'(MAX_PUSH) : AW'(push_cnt);

        if (flush) begin
            ack_ext = '0;
        end else if (req < free_ext) begin
            ack_ext = req;
        end else begin
            ack_ext = free_ext;
        end

        push_ack    = CNT_W'(ack_ext);
        free_cnt    = FREE_W'(free_ext);
        full        = (free_ext == '0);
        almost_full = (free_ext <= AW'(AF_THRESH));

        w_ptr_d = flush ? r_ptr : w_ptr_inc;

        // A refused push in the same cycle as clear_ovf keeps the flag set.
        if (!flush && (AW'(push_cnt) > free_ext)) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    sync_fifo_ptr_add #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_ptr_add (
        .ptr_i (w_ptr_q),
        .n_i   (push_ack),
        .ptr_o (w_ptr_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign w_ptr    = w_ptr_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sync_fifo_wptr_multi.sv
// Bench for sync_fifo_wptr_multi (DEPTH=6, MAX_PUSH=2, AF_THRESH=1): directed scenarios
// then random traffic, checked against a model of absolute entry counts modulo 2*DEPTH.
module tb_sync_fifo_wptr_multi;

    localparam int D  = 6;
    localparam int MP = 2;
    localparam int AF = 1;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] push_cnt;
    logic [3:0] r_ptr;
    logic       clear_ovf;
    logic [3:0] w_ptr;
    logic [1:0] push_ack;
    logic [2:0] free_cnt;
    logic       full;
    logic       almost_full;
    logic       overflow;

    int n_checks = 0;
    int n_err    = 0;

    // Model: positions counted in entries, modulo 2*D (the wrap bit is the D's place).
    int w_abs = 0;
    int r_abs = 0;
    bit ovf_m = 0;

    sync_fifo_wptr_multi #(
        .DEPTH     (D),
        .MAX_PUSH  (MP),
        .AF_THRESH (AF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push_cnt    (push_cnt),
        .r_ptr       (r_ptr),
        .clear_ovf   (clear_ovf),
        .w_ptr       (w_ptr),
        .push_ack    (push_ack),
        .free_cnt    (free_cnt),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ptr_of(input int a);
        return ((a >= D) ? 4'd8 : 4'd0) | 4'(a % D);
    endfunction

    function automatic int occ_m();
        return (w_abs - r_abs + 2 * D) % (2 * D);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive, check combinational outputs, clock, check registered state.
    task automatic cycle(input int pc, input bit fl, input bit co, input int r_new);
        int free_e, ack_e;
        r_abs     = r_new % (2 * D);
        r_ptr     = ptr_of(r_abs);
        push_cnt  = 2'(pc);
        flush     = fl;
        clear_ovf = co;
        #1;
        free_e = D - occ_m();
        ack_e  = fl ? 0 : ((pc < free_e) ? pc : free_e);
        check("free_cnt", 32'(free_cnt), 32'(free_e));
        check("push_ack", 32'(push_ack), 32'(ack_e));
        check("full", 32'(full), 32'(free_e == 0));
        check("almost_full", 32'(almost_full), 32'(free_e <= AF));
        @(posedge clk);
        #1;
        w_abs = fl ? r_abs : (w_abs + ack_e) % (2 * D);
        if (!fl && pc > free_e) ovf_m = 1'b1;
        else if (co) ovf_m = 1'b0;
        check("w_ptr", 32'(w_ptr), 32'(ptr_of(w_abs)));
        check("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    initial begin
        int pc, adv;
        bit fl, co;
        rst_n     = 1'b0;
        flush     = 1'b0;
        push_cnt  = '0;
        r_ptr     = '0;
        clear_ovf = 1'b0;
        #1;
        check("rst_w_ptr", 32'(w_ptr), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_free_cnt", 32'(free_cnt), 32'd6);
        check("rst_full", 32'(full), 32'h0);
        check("rst_almost_full", 32'(almost_full), 32'h0);
        #11;
        rst_n = 1'b1;

        // Fill from empty, then a refused push.
        for (int i = 0; i < 3; i++) cycle(2, 0, 0, 0);
        check("fill_w_ptr", 32'(w_ptr), 32'h8);
        cycle(2, 0, 0, 0);
        check("fill_hold_w_ptr", 32'(w_ptr), 32'h8);
        check("fill_overflow", 32'(overflow), 32'h1);

        // Reach w_ptr={1,3} with overflow set, then reset asynchronously mid-cycle.
        cycle(2, 0, 0, 3);
        cycle(1, 0, 0, 3);
        check("pre_rst_w_ptr", 32'(w_ptr), 32'hb);
        #2;
        r_ptr    = '0;
        push_cnt = '0;
        rst_n    = 1'b0;
        #1;
        w_abs = 0;
        r_abs = 0;
        ovf_m = 1'b0;
        check("async_rst_w_ptr", 32'(w_ptr), 32'h0);
        check("async_rst_overflow", 32'(overflow), 32'h0);
        check("async_rst_free_cnt", 32'(free_cnt), 32'd6);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Multi-push straddling idx 5 -> 0 at a non-power-of-two depth.
        cycle(2, 0, 0, 0);
        cycle(2, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(2, 0, 0, 5);
        check("wrap_w_ptr", 32'(w_ptr), 32'h9);

        // Partial acceptance with one free slot, then clear_ovf.
        cycle(2, 0, 0, 5);
        cycle(1, 0, 0, 5);
        cycle(2, 0, 0, 5);
        check("partial_w_ptr", 32'(w_ptr), 32'hd);
        check("partial_overflow", 32'(overflow), 32'h1);
        cycle(0, 0, 1, 5);
        check("cleared_overflow", 32'(overflow), 32'h0);

        // Almost-full stepping 3,2,1,0, then a same-cycle read frees a slot.
        cycle(1, 0, 0, 8);
        cycle(1, 0, 0, 8);
        cycle(1, 0, 0, 8);
        cycle(0, 0, 0, 8);
        cycle(1, 0, 0, 9);

        // Flush with a pending push and clear_ovf while overflow is set.
        cycle(0, 0, 0, 3);
        cycle(2, 0, 0, 3);
        cycle(2, 0, 0, 3);
        cycle(2, 0, 0, 3);
        cycle(1, 0, 0, 3);
        check("pre_flush_w_ptr", 32'(w_ptr), 32'hb);
        cycle(2, 1, 1, 7);
        check("flush_w_ptr", 32'(w_ptr), 32'h9);
        cycle(0, 0, 0, 7);

        // Random legal traffic: reads never pass the write pointer.
        for (int i = 0; i < 300; i++) begin
            adv = int'($urandom_range(32'(occ_m())));
            pc  = int'($urandom_range(MP));
            fl  = ($urandom_range(15) == 0);
            co  = ($urandom_range(7) == 0);
            cycle(pc, fl, co, r_abs + adv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
